// File: rtl/bridge_arb_pkg.sv
// Shared FSM state type, sizing helpers and the circular first-one search
// used by the bridge slave arbiter.
package bridge_arb_pkg;

  localparam int MAX_MASTER       = 32;
  localparam int N_MASTER_DEFAULT = 4;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int LOG_MASTER = clog2_min1(N_MASTER_DEFAULT);

  // First set bit of req at or after ptr, wrapping at n; 0 when req is empty.
  function automatic int ff1_rr(input logic [MAX_MASTER-1:0] req,
                                input int                    ptr,
                                input int                    n);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_MASTER; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/bridge_rr_prio_enc.sv
// Circular priority encoder: picks the first requester at or after i_ptr.
module bridge_rr_prio_enc
  import bridge_arb_pkg::*;
#(
  parameter int N_MASTER = 4,
  parameter int LOG_M    = clog2_min1(N_MASTER)
) (
  input  logic [N_MASTER-1:0] i_req,
  input  logic [LOG_M-1:0]    i_ptr,
  output logic [LOG_M-1:0]    o_winner,
  output logic                o_valid
);

  logic [MAX_MASTER-1:0] w_req_ext;

  assign w_req_ext = MAX_MASTER'(i_req);
  assign o_winner  = LOG_M'(ff1_rr(w_req_ext, int'(i_ptr), N_MASTER));
  assign o_valid   = |i_req;

endmodule

// File: rtl/bridge_slave_arbiter.sv
// Shares one bridge slave port between N_MASTER requesters and routes the
// 1-cycle read response back. Define BRIDGE_ARB_FIXED_PRIO_EN for fixed priority.
//
// state | meaning
// ARB   | winner chosen combinationally from live requests and rr pointer
// HOLD  | slave stalled; winner frozen in r_held until granted
module bridge_slave_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = N_MASTER
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                data_r_rdata_i
);

  localparam int               LOG_M = clog2_min1(N_MASTER);
  localparam logic [LOG_M-1:0] LAST  = LOG_M'(N_MASTER - 1);

  arb_state_e          r_state;
  logic [LOG_M-1:0]    r_held;
  logic [N_MASTER-1:0] r_resp_owner;
  logic                r_resp_pend;

  logic [LOG_M-1:0]    w_ptr;
  logic [LOG_M-1:0]    w_arb_winner;
  logic                w_arb_valid;
  logic [LOG_M-1:0]    w_winner;
  logic [N_MASTER-1:0] w_win_oh;
  logic                w_hs;

`ifdef BRIDGE_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [LOG_M-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_winner == LAST) ? '0 : w_winner + LOG_M'(1);
    end
  end

  assign w_ptr = r_rr_ptr;
`endif

  bridge_rr_prio_enc #(
    .N_MASTER (N_MASTER),
    .LOG_M    (LOG_M)
  ) u_prio_enc (
    .i_req    (data_req_i),
    .i_ptr    (w_ptr),
    .o_winner (w_arb_winner),
    .o_valid  (w_arb_valid)
  );

  assign w_winner   = (r_state == HOLD) ? r_held : w_arb_winner;
  assign data_req_o = (r_state == HOLD) ? data_req_i[r_held] : w_arb_valid;
  assign w_hs       = data_req_o & data_gnt_i;

  always_comb begin
    w_win_oh           = '0;
    w_win_oh[w_winner] = 1'b1;
  end

  // With nobody requesting the encoder returns 0, so master 0's fields go out.
  assign data_add_o   = data_add_i[w_winner];
  assign data_wen_o   = data_wen_i[w_winner];
  assign data_wdata_o = data_wdata_i[w_winner];
  assign data_be_o    = data_be_i[w_winner];
  assign data_ID_o    = ID_WIDTH'(w_win_oh);
  assign data_gnt_o   = w_hs ? w_win_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_held  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (data_req_o && !data_gnt_i) begin
            r_state <= HOLD;
            r_held  <= w_arb_winner;
          end
        end
        HOLD: begin
          // A held master dropping its request is abandoned, not granted.
          if (data_gnt_i || !data_req_i[r_held]) r_state <= ARB;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_owner <= '0;
      r_resp_pend  <= 1'b0;
    end else if (w_hs) begin
      r_resp_owner <= w_win_oh;
      r_resp_pend  <= 1'b1;
    end else begin
      r_resp_pend  <= 1'b0;
    end
  end

  assign data_r_valid_o = (data_r_valid_i && r_resp_pend) ? r_resp_owner : '0;
  assign data_r_rdata_o = data_r_rdata_i;

  a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
                                     data_r_valid_i |-> r_resp_pend);

endmodule

// File: doc/bridge_slave_arbiter.md
# bridge_slave_arbiter

Round-robin arbiter that shares one bridge slave port between N_MASTER requesters. Each input is the per-slave request line produced by a master's bridge request decoder. The block muxes the winning master's request onto the slave and returns the grant to that master only. It also routes the slave's fixed-latency read response back to the master that issued the request. It sits between the request decoders and each slave target in the XBAR_BRIDGE.

## Interface
- N_MASTER, 4, number of requesting masters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, N_MASTER, width of the one-hot ID field forwarded to the slave

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- data_req_i  in  N_MASTER  per-master request
- data_add_i  in  N_MASTER×ADDR_WIDTH  per-master address
- data_wen_i  in  N_MASTER  per-master write-enable, active-low (0 = write)
- data_wdata_i  in  N_MASTER×DATA_WIDTH  per-master write data
- data_be_i  in  N_MASTER×BE_WIDTH  per-master byte enables
- data_gnt_o  out  N_MASTER  per-master grant
- data_r_valid_o  out  N_MASTER  per-master response valid
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
- data_req_o  out  1  slave request
- data_add_o, data_wen_o, data_wdata_o, data_be_o  out  as above  slave request payload (winner's fields)
- data_ID_o  out  ID_WIDTH  one-hot ID of the winning master
- data_gnt_i  in  1  slave grant
- data_r_valid_i  in  1  slave response valid; asserted exactly 1 cycle after a request/grant handshake
- data_r_rdata_i  in  DATA_WIDTH  slave response data

## Operation
- Two-state FSM:
  - ARB: the winner is the first requesting master at or after rr_ptr, in circular order. The winner is combinational in this state.
  - HOLD: the winner is frozen in a register.
- Transitions:
  - ARB → HOLD when data_req_o=1 and data_gnt_i=0.
  - HOLD → ARB on the cycle where data_gnt_i=1.
  - In both states, a handshake sets rr_ptr ← (winner+1) mod N_MASTER.
- In HOLD, the held master's payload is forwarded to the slave.
  - If that master drops data_req_i, which is a protocol violation, data_req_o falls and the FSM returns to ARB. rr_ptr is unchanged.
- data_gnt_o[w] = data_gnt_i & data_req_o & (w == winner). All other grant bits are 0.
- data_req_o = |data_req_i in ARB, and data_req_i[held] in HOLD.
- When no master requests, data_req_o=0 and the payload outputs are don't-care. Implementation drives master 0's fields.
- Response routing:
  - On each handshake, resp_owner ← one-hot(winner) and resp_pend ← 1.
  - With no handshake, resp_pend ← 0.
  - data_r_valid_o = data_r_valid_i ? resp_owner : 0.
- Back-to-back handshakes are supported: resp_owner is overwritten every cycle. No FIFO is needed, because slave latency is exactly 1.
- data_r_valid_i=1 while resp_pend=0 is a slave protocol error: no master sees a valid. An assertion fires in simulation.
- Reset values:
  - FSM=ARB, rr_ptr=0, resp_owner=0, resp_pend=0.
  - Resulting outputs: data_gnt_o=0 and data_r_valid_o=0. data_req_o follows the inputs.

## Timing
- Request path is combinational. A grant reaches the master in the same cycle it is given.
- Response is routed combinationally from data_r_valid_i to data_r_valid_o, one cycle after the handshake.
- Priority update takes effect the cycle after a handshake.
- Reset asserted mid-transaction: state is cleared immediately. A response in flight is dropped (no data_r_valid_o).
- Simultaneous new requests during HOLD are ignored until the return to ARB.

## Configuration
- BRIDGE_ARB_FIXED_PRIO_EN
  - Defined: rr_ptr is removed and master 0 always has highest priority, descending by index. HOLD behaviour is unchanged.
  - Undefined (default): round-robin as above.

## Structure
- Shared package bridge_arb_pkg holds:
  - the FSM state enum {ARB, HOLD};
  - function ff1_rr(req, ptr) returning the winner index;
  - localparam LOG_MASTER = $clog2(N_MASTER) (minimum 1).
- One sub-module is natural: bridge_rr_prio_enc, the circular priority encoder (request vector + pointer → winner index + valid).

## Test plan
- Reset, then all four masters request continuously with data_gnt_i=1 → grants rotate m0,m1,m2,m3,m0. data_r_valid_o is one-hot to the previous cycle's winner.
- m2 requests with data_gnt_i=0 for 3 cycles while m0 and m1 assert mid-stall → data_ID_o=4'b0100 and the payload is stable for all 3 cycles. On grant, m2 is granted, and the next winner is m3 if requesting, otherwise m0.
- Only m1 requests, a write of 0xDEAD_BEEF to 0x1C00_0010 with be=4'hF → slave sees exactly those fields and data_gnt_o=4'b0010.
- Read handshake by m3, then data_r_valid_i=1 with rdata=0x1234_5678 the next cycle → data_r_valid_o=4'b1000 and data_r_rdata_o=0x1234_5678.
- rst_n asserted the cycle after a handshake → no data_r_valid_o pulse. After reset, m0 wins the first arbitration.
- With BRIDGE_ARB_FIXED_PRIO_EN defined and m0 and m3 requesting continuously → m0 is granted every cycle and m3 is never granted.
